// File: rtl/atomrv_lsu_if.sv
// Core-side request/response and data-bus bundles for the AtomRV LSU.
// Latency: none, wires only.
// Backpressure: core side uses req_ready_o; the bus side stalls via d_ack_i.

interface atomrv_lsu_core_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic [1:0]        resp_err_o;

  // Core side drives requests and consumes responses.
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  // LSU side accepts requests and produces responses.
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

interface atomrv_lsu_dbus_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              d_cyc_o;
  logic              d_we_o;
  logic [ADDR_W-1:0] d_addr_o;
  logic [XLEN/8-1:0] d_sel_o;
  logic [XLEN-1:0]   d_data_o;
  logic [XLEN-1:0]   d_data_i;
  logic              d_ack_i;

  // LSU side issues bus cycles.
  modport master (
    output d_cyc_o, d_we_o, d_addr_o, d_sel_o, d_data_o,
    input  d_data_i, d_ack_i
  );

  // Memory side answers bus cycles.
  modport slave (
    input  d_cyc_o, d_we_o, d_addr_o, d_sel_o, d_data_o,
    output d_data_i, d_ack_i
  );
endinterface

// File: rtl/atomrv_lsu.sv
// Load/store unit: lane steering, byte selects, load extension, misalign check, bus timeout.
// Latency: aligned access responds 2+N cycles after accept (N wait states); misaligned in 1.
// Backpressure: one request in flight, ready only in IDLE; responses are a one-cycle pulse.

module atomrv_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  atomrv_lsu_core_if.slave  core,
  atomrv_lsu_dbus_if.master dbus
);

  localparam int SEL_W = XLEN / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic [OFF_W-1:0] lat_off;

  logic [OFF_W-1:0] req_off;
  logic             req_bad;
  logic [SEL_W-1:0] size_mask;
  logic [SEL_W-1:0] req_sel;
  logic [XLEN-1:0]  req_lane_data;
  logic [XLEN-1:0]  rd_shift;
  logic [XLEN-1:0]  rd_keep;
  logic             rd_sign;
  logic [XLEN-1:0]  load_ext;

  // Request decode: alignment check, byte-lane mask and write-data steering.
  always_comb begin
    req_off = core.req_addr_i[OFF_W-1:0];
    req_bad = 1'b0;
    size_mask = '0;
    case (core.req_size_i)
      2'b00: begin
        req_bad   = 1'b0;
        size_mask = SEL_W'(8'h01);
      end
      2'b01: begin
        req_bad   = core.req_addr_i[0];
        size_mask = SEL_W'(8'h03);
      end
      2'b10: begin
        req_bad   = |core.req_addr_i[1:0];
        size_mask = SEL_W'(8'h0F);
      end
      default: begin
        // Doubleword only exists on a 64-bit datapath.
        req_bad   = (XLEN == 32) || (|core.req_addr_i[2:0]);
        size_mask = SEL_W'(8'hFF);
      end
    endcase
    req_sel       = size_mask << req_off;
    req_lane_data = core.req_wdata_i << {req_off, 3'b000};
  end

  // Load return path: bring the addressed lane down, truncate, then extend.
  always_comb begin
    rd_shift = dbus.d_data_i >> {lat_off, 3'b000};
    rd_keep  = '1;
    rd_sign  = 1'b0;
    case (lat_size)
      2'b00: begin
        rd_keep = XLEN'(64'h0000_0000_0000_00FF);
        rd_sign = rd_shift[7];
      end
      2'b01: begin
        rd_keep = XLEN'(64'h0000_0000_0000_FFFF);
        rd_sign = rd_shift[15];
      end
      2'b10: begin
        rd_keep = XLEN'(64'h0000_0000_FFFF_FFFF);
        rd_sign = rd_shift[31];
      end
      default: begin
        rd_keep = '1;
        rd_sign = 1'b0;
      end
    endcase
    load_ext = (rd_shift & rd_keep) | ((rd_sign && !lat_uns) ? ~rd_keep : '0);
  end

  // Control FSM with all core and bus outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= S_IDLE;
      tmo_cnt           <= '0;
      lat_size          <= 2'b00;
      lat_uns           <= 1'b0;
      lat_off           <= '0;
      core.req_ready_o  <= 1'b1;
      core.resp_valid_o <= 1'b0;
      core.resp_rdata_o <= '0;
      core.resp_err_o   <= 2'b00;
      dbus.d_cyc_o      <= 1'b0;
      dbus.d_we_o       <= 1'b0;
      dbus.d_addr_o     <= '0;
      dbus.d_sel_o      <= '0;
      dbus.d_data_o     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core.req_valid_i) begin
            core.req_ready_o <= 1'b0;
            lat_size         <= core.req_size_i;
            lat_uns          <= core.req_unsigned_i;
            lat_off          <= req_off;
            if (req_bad) begin
              // Rejected requests never touch the bus.
              state             <= S_RESP;
              core.resp_valid_o <= 1'b1;
              core.resp_rdata_o <= '0;
              core.resp_err_o   <= 2'b01;
            end else begin
              state         <= S_BUS;
              tmo_cnt       <= '0;
              dbus.d_cyc_o  <= 1'b1;
              dbus.d_we_o   <= core.req_we_i;
              dbus.d_addr_o <= {core.req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              dbus.d_sel_o  <= req_sel;
              dbus.d_data_o <= req_lane_data;
            end
          end
        end
        S_BUS: begin
          // An ack on the final timeout edge still completes normally.
          if (dbus.d_ack_i) begin
            state             <= S_RESP;
            core.resp_valid_o <= 1'b1;
            core.resp_rdata_o <= dbus.d_we_o ? '0 : load_ext;
            core.resp_err_o   <= 2'b00;
            dbus.d_cyc_o      <= 1'b0;
            dbus.d_we_o       <= 1'b0;
            dbus.d_sel_o      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
              state             <= S_RESP;
              core.resp_valid_o <= 1'b1;
              core.resp_rdata_o <= '0;
              core.resp_err_o   <= 2'b10;
              dbus.d_cyc_o      <= 1'b0;
              dbus.d_we_o       <= 1'b0;
              dbus.d_sel_o      <= '0;
            end
          end
        end
        S_RESP: begin
          state             <= S_IDLE;
          core.resp_valid_o <= 1'b0;
          core.req_ready_o  <= 1'b1;
        end
        default: begin
          state            <= S_IDLE;
          core.req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/atomrv_lsu.md
# atomrv_lsu

Parametrised load/store unit that connects the AtomRV execute stage to a data memory with wait states. It adds byte/halfword/word (and doubleword at XLEN=64) accesses with lane steering, byte selects, sign/zero extension, misalignment detection and a bus timeout. It sits between the core's DMEM port and the data bus. The core presents one request at a time and sees exactly one response per accepted request.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, number of BUS-state edges without `d_ack_i` before the access is aborted; must be ≥1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset; one clock; asynchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  LSU can accept a request (IDLE only).
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 double; 11 is legal only when XLEN=64.
- req_unsigned_i  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  XLEN  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- resp_err_o  out  2  00 ok, 01 misaligned or illegal size, 10 timeout.
- d_cyc_o  out  1  bus cycle active.
- d_we_o  out  1  bus write.
- d_addr_o  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero).
- d_sel_o  out  XLEN/8  byte-lane enables.
- d_data_o  out  XLEN  write data shifted into its lane(s).
- d_data_i  in  XLEN  read data.
- d_ack_i  in  1  bus acknowledge.

## Operation
- The FSM has three states: IDLE, BUS and RESP. Reset state is IDLE.
- Reset values:
  - req_ready_o=1.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=00.
  - d_cyc_o=0, d_we_o=0, d_addr_o=0, d_sel_o=0, d_data_o=0.
  - Timeout counter = 0.
- **IDLE:** req_ready_o=1. A request is accepted on an edge where req_valid_i=1.
  - A request is misaligned if any of the following holds: size half with addr[0]≠0; size word with addr[1:0]≠0; size double with addr[2:0]≠0. size=11 at XLEN=32 is also treated as an error.
  - A misaligned or illegal request goes to RESP with err=01. No bus cycle is issued.
  - Otherwise the LSU registers the bus outputs and moves to BUS with the counter cleared:
    - d_cyc_o=1 and d_we_o=req_we_i.
    - d_addr_o = addr with its low lane bits cleared.
    - d_sel_o = size mask (1, 3, F or FF) shifted left by addr offset.
    - d_data_o = wdata shifted left by 8·offset.
    - The load parameters (size, unsigned, offset) are latched for the response.
- **BUS:** all d_* outputs are held stable. req_ready_o=0.
  - On an edge with d_ack_i=1 the LSU goes to RESP.
    - Loads: d_data_i is shifted right by 8·offset, truncated to the access size, then sign- or zero-extended to XLEN.
    - Stores: resp_rdata_o=0.
    - err=00.
  - On an edge with d_ack_i=0 the counter increments.
  - If the edge is the TIMEOUT-th BUS edge and d_ack_i=0, the LSU goes to RESP with err=10 and rdata=0.
  - If ack arrives on that same edge, ack wins and the response is ok.
  - d_cyc_o, d_we_o and d_sel_o go to 0 on exit from BUS.
- **RESP:** resp_valid_o=1 for exactly one cycle, then the LSU returns to IDLE. The response has no backpressure.
  - resp_rdata_o and resp_err_o are valid only while resp_valid_o=1 and otherwise hold their last value.
- d_ack_i is ignored in IDLE and RESP. req_valid_i is ignored outside IDLE.

## Timing
- Accept edge E0. d_cyc_o is high in the cycle after E0.
- Zero-wait memory (ack sampled at E1): resp_valid_o is high between E1 and E2. The LSU is ready again after E2.
- Latency:
  - Aligned access: response in 2 + N cycles after accept, for N wait states.
  - Misaligned access: response in 1 cycle.
  - Peak throughput is one access per 3 cycles.
- All outputs are registered. There are no combinational paths from req_* or d_* inputs to outputs.
- Asserting rst_n_i mid-access immediately (asynchronously) forces d_cyc_o=0, resp_valid_o=0 and IDLE. No response is produced for the aborted request.
- Counter width is clog2(TIMEOUT+1). The counter never wraps because BUS exits at TIMEOUT.

## Test plan
- **Byte load, XLEN=32:** addr 0x103, size 00, signed; memory returns 0x80AABBCC with 0 waits.
  - Required: d_addr_o=0x100, d_sel_o=1000, resp_rdata_o=0xFFFFFF80 and err=00 on the 2nd edge after accept.
- **Half store:** addr 0x202, wdata 0x0000BEEF, with 3 wait states.
  - Required: d_sel_o=1100, d_data_o=0xBEEF0000 and d_we_o=1, all held for 4 cycles; resp_rdata_o=0 and err=00.
- **Misaligned word load:** addr 0x101.
  - Required: d_cyc_o stays 0, resp_valid_o pulses 1 cycle after accept, err=01.
- **Timeout:** TIMEOUT=4, ack never asserted.
  - Required: d_cyc_o high for exactly 4 cycles, then resp err=10, rdata=0, and req_ready_o=1 the next cycle.
  - Repeat with ack on the 4th edge: required err=00.
- **XLEN=64:** unsigned word load at addr 0x14, memory returns 0xDEADBEEF_00000000.
  - Required: d_sel_o=0xF0, resp_rdata_o=0x00000000DEADBEEF.
- **Reset mid-access:** assert rst_n_i low during BUS.
  - Required: d_cyc_o drops in the same cycle, resp_valid_o is never raised, and after release req_ready_o=1 with all outputs at their reset values.
